// File: rtl/pnu_btn_pkg.sv
// pnu_btn_pkg: shared push-button types and default timing constants
package pnu_btn_pkg;
    typedef enum logic [1:0] {IDLE, PRESSED, HELD} btn_state_t;
    localparam int BTN_SYNC_STAGES = 2;
    localparam int BTN_DEB_DEFAULT = 16;
    localparam int BTN_HOLD_DEFAULT = 64;
endpackage

// File: rtl/pnu_sync2.sv
// pnu_sync2: two-flop synchroniser for an asynchronous pad input
module pnu_sync2
    import pnu_btn_pkg::*;
#(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [BTN_SYNC_STAGES-1:0] sr;
    // shift the pad value through the chain; reset parks it at the idle level
    always_ff @(posedge clk or negedge rst)
        if (!rst) sr <= {BTN_SYNC_STAGES{RST_VAL}};
        else sr <= {sr[BTN_SYNC_STAGES-2:0], d};
    assign q = sr[BTN_SYNC_STAGES-1];
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and classify a push-button into level and event pulses
module button_conditioner
    import pnu_btn_pkg::*;
#(
    parameter int DEB_CYCLES = BTN_DEB_DEFAULT,
    parameter int HOLD_CYCLES = BTN_HOLD_DEFAULT,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic long_press,
    output logic btn_hold
);
    localparam int CNT_W = $clog2(DEB_CYCLES > HOLD_CYCLES ? DEB_CYCLES : HOLD_CYCLES) + 1;
    logic synced, s, flip, rise, fall;
    logic [CNT_W-1:0] deb_cnt, hold_cnt;
    btn_state_t state;
    pnu_sync2 #(.RST_VAL(ACTIVE_LOW)) u_sync (.clk(clk), .rst(rst), .d(button_raw), .q(synced));
    assign s = synced ^ ACTIVE_LOW;
    assign flip = (s != btn_level) && (deb_cnt == CNT_W'(DEB_CYCLES - 1));
    assign rise = flip && !btn_level;
    assign fall = flip && btn_level;
    // accept a level change only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            btn_level <= 1'b0;
            deb_cnt <= '0;
        end else begin
            btn_level <= btn_level ^ flip;
            deb_cnt <= (s == btn_level || flip) ? '0 : deb_cnt + 1'b1;
        end
    // press/hold FSM; release takes priority over a hold completing on the same edge
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            hold_cnt <= '0;
            btn_press <= 1'b0;
            btn_release <= 1'b0;
            long_press <= 1'b0;
            btn_hold <= 1'b0;
        end else begin
            btn_press <= rise;
            btn_release <= fall;
            long_press <= 1'b0;
            case (state)
                IDLE:
                    if (rise) begin
                        state <= PRESSED;
                        hold_cnt <= '0;
                    end
                PRESSED:
                    if (fall) state <= IDLE;
                    else if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        state <= HELD;
                        long_press <= 1'b1;
                        btn_hold <= 1'b1;
                    end else hold_cnt <= hold_cnt + 1'b1;
                HELD:
                    if (fall) begin
                        state <= IDLE;
                        btn_hold <= 1'b0;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: randomized scoreboard bench against a window-based behavioural model
module tb_button_conditioner;
    localparam int DEB = 4;
    logic clk = 1'b0, rst = 1'b0, raw0 = 1'b0, raw1 = 1'b1;
    logic [4:0] o0, o1, o2;
    int total = 0, bad = 0;
    int npress = 0, nrel = 0, nlong = 0;
    logic [4:0] exp_q0[$], exp_q1[$];
    logic m_sq[$], m_w[$];
    logic m_lvl;
    int m_age[2];
    bit m_held[2];
    int hold_len[2] = '{8, 1};

    always #5 clk = ~clk;

    button_conditioner #(.DEB_CYCLES(DEB), .HOLD_CYCLES(8), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .button_raw(raw0), .btn_level(o0[4]), .btn_press(o0[3]),
        .btn_release(o0[2]), .long_press(o0[1]), .btn_hold(o0[0]));
    button_conditioner #(.DEB_CYCLES(DEB), .HOLD_CYCLES(8), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .button_raw(raw1), .btn_level(o1[4]), .btn_press(o1[3]),
        .btn_release(o1[2]), .long_press(o1[1]), .btn_hold(o1[0]));
    button_conditioner #(.DEB_CYCLES(DEB), .HOLD_CYCLES(1), .ACTIVE_LOW(1'b0)) dut2 (
        .clk(clk), .rst(rst), .button_raw(raw0), .btn_level(o2[4]), .btn_press(o2[3]),
        .btn_release(o2[2]), .long_press(o2[1]), .btn_hold(o2[0]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // the button counts as pressed once the last DEB synchronised samples all disagree with the level
    task automatic model_edge(input logic p);
        logic s, lp;
        bit all_diff, rise, fall;
        s = m_sq.pop_front();
        m_sq.push_back(p);
        m_w.push_back(s);
        if (m_w.size() > DEB) void'(m_w.pop_front());
        all_diff = (m_w.size() == DEB);
        foreach (m_w[i]) if (m_w[i] == m_lvl) all_diff = 0;
        rise = all_diff && !m_lvl;
        fall = all_diff && m_lvl;
        if (all_diff) m_lvl = !m_lvl;
        for (int m = 0; m < 2; m++) begin
            lp = 1'b0;
            if (rise) begin
                m_age[m] = 0;
                m_held[m] = 0;
            end else if (fall) m_held[m] = 0;
            else if (m_lvl) begin
                m_age[m]++;
                if (!m_held[m] && m_age[m] == hold_len[m]) begin
                    lp = 1'b1;
                    m_held[m] = 1;
                end
            end
            if (m == 0) exp_q0.push_back({m_lvl, rise, fall, lp, m_held[m]});
            else exp_q1.push_back({m_lvl, rise, fall, lp, m_held[m]});
        end
    endtask

    task automatic model_clear();
        m_sq = '{1'b0, 1'b0};
        m_w.delete();
        m_lvl = 1'b0;
        m_held = '{0, 0};
        m_age = '{0, 0};
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic tick(input logic p);
        raw0 = p;
        raw1 = ~p;
        @(posedge clk);
        if (rst) model_edge(p);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic p);
        settle();
        raw0 = p;
        raw1 = ~p;
        rst = 1'b0;
        #1;
        chk("async_reset_dut0", o0, 0);
        chk("async_reset_dut1", o1, 0);
        chk("async_reset_dut2", o2, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold_dut0", o0, 0);
        rst = 1'b1;
    endtask

    // monitor: compare every presented output against the queued prediction
    always @(negedge clk) begin
        if (exp_q0.size() > 0) begin
            logic [4:0] e0, e1;
            e0 = exp_q0.pop_front();
            e1 = exp_q1.pop_front();
            chk("sb_dut0", o0, e0);
            chk("sb_dut1_active_low", o1, e0);
            chk("sb_dut2_hold1", o2, e1);
            npress += int'(o0[3]);
            nrel += int'(o0[2]);
            nlong += int'(o0[1]);
        end
    end

    initial begin
        int p0, r0, l0, len;
        logic v;
        model_clear();
        // reset with the button held, then count the press latency
        do_reset(1'b1);
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1);
            if (i == 5) chk("latency_before", {o0[4], o0[3]}, 2'b00);
        end
        chk("latency_press", {o0[4], o0[3]}, 2'b11);
        repeat (12) tick(1'b0);
        // bounce
        settle();
        p0 = npress; r0 = nrel;
        for (int i = 0; i < 4; i++) repeat (2) tick(i % 2 == 0);
        repeat (12) tick(1'b1);
        settle();
        chk("bounce_presses", npress - p0, 1);
        chk("bounce_releases", nrel - r0, 0);
        repeat (12) tick(1'b0);
        // glitch shorter than the debounce window
        settle();
        p0 = npress; r0 = nrel;
        repeat (3) tick(1'b1);
        repeat (10) tick(1'b0);
        settle();
        chk("glitch_presses", npress - p0, 0);
        chk("glitch_level", o0[4], 1'b0);
        // long press
        l0 = nlong;
        repeat (20) tick(1'b1);
        settle();
        chk("long_hold_level", o0[0], 1'b1);
        repeat (10) tick(1'b0);
        settle();
        chk("long_press_count", nlong - l0, 1);
        // short press, then a release landing on the hold completion edge
        l0 = nlong;
        repeat (5) tick(1'b1);
        repeat (10) tick(1'b0);
        repeat (8) tick(1'b1);
        repeat (10) tick(1'b0);
        settle();
        chk("short_no_long", nlong - l0, 0);
        // randomized segments with occasional resets
        for (int k = 0; k < 40; k++) begin
            v = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 14);
            repeat (len) tick(v);
            if ($urandom_range(0, 11) == 0) do_reset(v);
        end
        repeat (12) tick(1'b0);
        // reset while held, then a fresh press with the button still down
        repeat (16) tick(1'b1);
        settle();
        chk("held_before_reset", o0[0], 1'b1);
        do_reset(1'b1);
        repeat (6) tick(1'b1);
        chk("press_after_reset", {o0[4], o0[3]}, 2'b11);
        repeat (12) tick(1'b0);
        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
